// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pkg
// Description : Shared NPU definitions: destination select codes, demux_in
//               FSM encoding and header field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

    localparam int NUM_DST   = 5;
    localparam int HDR_LEN_W = 5;

    localparam logic [2:0] SEL_FIFO = 3'd0;
    localparam logic [2:0] SEL_SIPO = 3'd1;
    localparam logic [2:0] SEL_CMP  = 3'd2;
    localparam logic [2:0] SEL_RELU = 3'd3;
    localparam logic [2:0] SEL_MAC  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    function automatic logic sel_is_valid(input logic [2:0] sel);
        return (sel <= SEL_MAC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_in_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_in_if
// Description : Host-side byte stream and per-destination handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_in_if;
    import npu_pkg::*;

    logic [7:0]         D_IN;
    logic               WR_EN;
    logic               BUSY;
    logic [7:0]         dst_data;
    logic [NUM_DST-1:0] dst_valid;
    logic [NUM_DST-1:0] dst_ready;
    logic               FRAME_DONE;
    logic               ERR;

    modport master (
        output D_IN, WR_EN, dst_ready,
        input  BUSY, dst_data, dst_valid, FRAME_DONE, ERR
    );

    modport slave (
        input  D_IN, WR_EN, dst_ready,
        output BUSY, dst_data, dst_valid, FRAME_DONE, ERR
    );
endinterface
`default_nettype wire

// File: rtl/demux_in_buf.sv
`default_nettype none
// ============================================================================
// Module      : demux_in_buf
// Description : Circular buffer of DEPTH entries holding a payload byte and a
//               3-bit destination tag; head entry is presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_in_buf #(
    parameter int DEPTH = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       push,
    input  wire logic [7:0] push_data,
    input  wire logic [2:0] push_tag,
    input  wire logic       pop,
    output logic            full,
    output logic            empty,
    output logic [7:0]      head_data,
    output logic [2:0]      head_tag
);
    localparam int                c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL_CNT = DEPTH[c_PTR_W:0];
    localparam logic [c_PTR_W:0]  c_CNT_ONE  = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [7:0]         r_data [DEPTH];
    logic [2:0]         r_tag  [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [7:0]         r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (push) begin
                r_data[r_wr_ptr] <= push_data;
                r_tag[r_wr_ptr]  <= push_tag;
                r_wr_ptr         <= r_wr_ptr + c_PTR_ONE;
            end
            // Remember the departing byte so dst_data holds it once empty
            if (pop) begin
                r_last   <= r_data[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign full      = (r_count == c_FULL_CNT);
    assign empty     = (r_count == '0);
    assign head_data = empty ? r_last : r_data[r_rd_ptr];
    assign head_tag  = r_tag[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/demux_in.sv
`default_nettype none
// ============================================================================
// Module      : demux_in
// Description : Framed host byte stream demultiplexer to five NPU units.
//               Optional frame-abort timeout enabled by DEMUX_IN_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_in
    import npu_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic CLKEXT,
    input  wire logic RST_GLO,
    demux_in_if.slave bus
);
    localparam logic [HDR_LEN_W:0] c_REM_ONE = (HDR_LEN_W+1)'(1);

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_sel, w_sel_nxt;
    logic [HDR_LEN_W:0]   r_rem, w_rem_nxt;
    logic                 r_frame_done, w_frame_done_nxt;
    logic                 r_err, w_err_nxt;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_timeout;
    logic [7:0]           w_head_data;
    logic [2:0]           w_head_tag;
    logic [NUM_DST-1:0]   w_valid;

    assign w_accept = bus.WR_EN && !w_full;

`ifdef DEMUX_IN_TIMEOUT_EN
    localparam int                c_TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_END = c_TO_W'(TIMEOUT_CYC - 1);

    logic [c_TO_W-1:0] r_idle;

    // Fires on the TIMEOUT_CYC-th consecutive idle cycle inside a frame
    assign w_timeout = (r_state != ST_IDLE) && !w_accept && (r_idle == c_TO_END);

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) begin
            r_idle <= '0;
        end else if ((r_state == ST_IDLE) || w_accept || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + c_TO_W'(1);
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_rem        <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_rem        <= w_rem_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_sel_nxt        = r_sel;
        w_rem_nxt        = r_rem;
        w_frame_done_nxt = 1'b0;
        w_err_nxt        = r_err;
        w_push           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_sel_nxt = bus.D_IN[2:0];
                    w_rem_nxt = {1'b0, bus.D_IN[7:3]} + c_REM_ONE;
                    if (sel_is_valid(bus.D_IN[2:0])) begin
                        w_state_nxt = ST_PAYLOAD;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    w_push    = 1'b1;
                    w_rem_nxt = r_rem - c_REM_ONE;
                    if (r_rem == c_REM_ONE) begin
                        w_state_nxt      = ST_IDLE;
                        w_frame_done_nxt = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (w_accept) begin
                    w_rem_nxt = r_rem - c_REM_ONE;
                    if (r_rem == c_REM_ONE) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    demux_in_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (CLKEXT),
        .rst       (RST_GLO),
        .push      (w_push),
        .push_data (bus.D_IN),
        .push_tag  (r_sel),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head_data (w_head_data),
        .head_tag  (w_head_tag)
    );

    assign w_valid        = w_empty ? '0 : (NUM_DST'(1) << w_head_tag);
    assign w_pop          = |(w_valid & bus.dst_ready);

    assign bus.BUSY       = w_full;
    assign bus.dst_data   = w_head_data;
    assign bus.dst_valid  = w_valid;
    assign bus.FRAME_DONE = r_frame_done;
    assign bus.ERR        = r_err;

endmodule
`default_nettype wire

// File: doc/demux_in.md
Name: demux_in

Overview:
- Input-side counterpart of the output mux. Host writes a framed byte stream on D_IN; the block routes payload bytes to one of five NPU units: FIFO, SIPO, CMP, RELU or MAC.
- Each frame is one header byte followed by 1..32 payload bytes.
- Payload bytes pass through a small tagged buffer with per-destination valid/ready handshake, so a stalled unit back-pressures the host through BUSY.

Parameters:
- DEPTH, 2, buffer entries (power of two, 2..8).
- TIMEOUT_CYC, 255, idle cycles in PAYLOAD before frame abort (used only with DEMUX_IN_TIMEOUT_EN).

Ports:
- CLKEXT  in  1  sole clock, rising edge.
- RST_GLO  in  1  asynchronous, active-high reset.
- D_IN  in  8  host byte (header or payload).
- WR_EN  in  1  host write strobe; byte accepted when WR_EN && !BUSY at a rising edge.
- BUSY  out  1  buffer full; host must hold the byte.
- dst_data  out  8  head-of-buffer byte, shared by all destinations.
- dst_valid  out  5  one-hot: bit0 FIFO, bit1 SIPO, bit2 CMP, bit3 RELU, bit4 MAC.
- dst_ready  in  5  per-destination ready.
- FRAME_DONE  out  1  one-cycle pulse when the last payload byte of a frame is accepted.
- ERR  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, RST_GLO=1): FSM=IDLE, buffer empty, BUSY=0, dst_data=8'h00, dst_valid=0, FRAME_DONE=0, ERR=0, counters=0. Reset mid-frame drops all buffered and pending bytes; no partial delivery afterwards.
- Header format: D_IN[2:0]=SEL, same coding as SEL_OUT (000 FIFO, 001 SIPO, 010 CMP, 011 RELU, 100 MAC, 101..111 invalid). D_IN[7:3]=LEN-1.
- FSM states:
  - IDLE: accepted byte is a header. Latch SEL, load remaining count with D_IN[7:3]+1, go to PAYLOAD (valid SEL) or DISCARD (invalid SEL; ERR<=1). Headers never enter the buffer.
  - PAYLOAD: each accepted byte is pushed with a 3-bit SEL tag and the count decrements. The byte at count==1 pulses FRAME_DONE next cycle and returns to IDLE.
  - DISCARD: accepted bytes are dropped, the count decrements identically, and the last byte returns to IDLE. No FRAME_DONE.
- BUSY = (occupancy==DEPTH), registered from occupancy. Headers and DISCARD bytes never touch the buffer, but BUSY gates all acceptance uniformly.
- Buffer behaviour:
  - Circular, DEPTH entries, 8-bit data + 3-bit tag.
  - Wrap-around on pointer overflow.
  - Push and pop in the same cycle leave occupancy unchanged. Pushing into a full buffer is impossible because of BUSY.
- Output side:
  - dst_data and tag are taken from the head entry (registered storage). With an empty buffer, dst_data holds its last value.
  - dst_valid = one-hot(tag) when not empty, else 0.
  - Pop when (dst_valid & dst_ready) != 0.
  - Latency: byte accepted at edge N is visible with dst_valid at edge N+1 if the buffer was empty.
- Frames are back-to-back: a header may be accepted the cycle after the last payload byte. Bytes of consecutive frames to different destinations coexist in the buffer and are delivered strictly in order. A stalled head blocks all later bytes, with no reordering.
- The host drives WR_EN only with valid data. D_IN is don't-care when WR_EN=0.

Optional Feature:
- Macro: DEMUX_IN_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in PAYLOAD or DISCARD with no accepted byte, and resets on acceptance.
  - On reaching TIMEOUT_CYC: FSM->IDLE, ERR<=1, no FRAME_DONE.
  - Already-buffered bytes are still delivered.
- Undefined: no counter; the FSM waits indefinitely for payload.

Decomposition:
- Package npu_pkg holds:
  - SEL codes (SEL_FIFO=3'd0 .. SEL_MAC=3'd4), shared with mux_out.
  - FSM state encoding ST_IDLE / ST_PAYLOAD / ST_DISCARD.
  - NUM_DST=5 and HDR_LEN_W=5.
- Sub-module demux_in_buf: tagged circular buffer (DEPTH, push/pop, full/empty, head data/tag). The top level keeps the FSM, the counters and the one-hot decode.

Test Plan:
1. Reset: RST_GLO=1 for 2 cycles, then release → BUSY=0, dst_valid=5'b0, dst_data=8'h00, ERR=0. Assert RST_GLO mid-frame asynchronously → outputs clear immediately, before the next edge.
2. Header 8'h12 (SEL=010, LEN=3), then A1, B2, C3 with dst_ready=5'b11111 → dst_valid=5'b00100 carrying A1, B2, C3 on consecutive cycles, each 1 cycle after acceptance; FRAME_DONE pulses once after C3.
3. Backpressure, DEPTH=2: header 8'h0C (MAC, LEN=2), then D4, E5 with dst_ready=0 → BUSY=1 after the second push. Raise dst_ready[4] → D4 then E5 popped; BUSY falls the cycle after the first pop.
4. Invalid SEL: header 8'h0E (SEL=110, LEN=2), bytes 11, 22, then header 8'h00 (FIFO, LEN=1) and byte 33 → ERR=1; 11/22 never appear; 33 appears with dst_valid=5'b00001.
5. Back-to-back frames: 8'h00,A1 (FIFO) then 8'h01,B2 (SIPO) with dst_ready=5'b00010 → A1 blocks at head until dst_ready[0]=1; delivery order is A1 then B2.
6. With DEMUX_IN_TIMEOUT_EN and TIMEOUT_CYC=4: header 8'h1B (RELU, LEN=4), one byte D4, then WR_EN=0 for 4 cycles → ERR=1, FSM back to IDLE, D4 still delivered. The next byte 8'h00 is treated as a header.
